// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART TX feeder and RX side.
package uart_pkg;
    localparam int UART_DATA_W = 8;
    typedef enum logic [1:0] {F_IDLE, F_WAIT_BUSY, F_WAIT_DONE} feeder_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock show-ahead FIFO with synchronous flush and occupancy count.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              wr_ok, rd_ok;
    assign full    = level_q == LVL_FULL;
    assign empty   = level_q == '0;
    assign level   = level_q;
    assign rd_data = mem[rd_ptr_q];
    // Flush wins over both ports; power-of-two depth lets pointers wrap naturally.
    always_comb begin
        wr_ok    = wr_en && !full && !flush;
        rd_ok    = rd_en && !empty && !flush;
        wr_ptr_d = flush ? '0 : wr_ptr_q + ADDR_W'(wr_ok);
        rd_ptr_d = flush ? '0 : rd_ptr_q + ADDR_W'(rd_ok);
        level_d  = flush ? '0 : level_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers stream bytes and launches them one at a time into the UART core TX port.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 8,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   flush,
    input  logic                   tx_hold,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_en,
    input  logic                   tx_busy,
    output logic [ADDR_W:0]        fifo_level,
    output logic                   byte_sent,
    output logic                   busy_timeout
);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    feeder_state_t          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d, head;
    logic                   tx_en_q, tx_en_d, byte_sent_q, byte_sent_d;
    logic                   busy_timeout_q, busy_timeout_d;
    logic                   launch, timed_out, full, empty;
    uart_sync_fifo #(.WIDTH(UART_DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (s_valid && s_ready),
        .wr_data (s_data),
        .rd_en   (launch),
        .rd_data (head),
        .flush   (flush),
        .level   (fifo_level),
        .full    (full),
        .empty   (empty)
    );
    assign s_ready      = !full && !flush;
    assign launch       = state_q == F_IDLE && !empty && !tx_busy && !tx_hold && !flush;
    assign timed_out    = state_q == F_WAIT_BUSY && !tx_busy && cnt_q == CNT_LAST;
    assign tx_en        = tx_en_q;
    assign tx_data      = tx_data_q;
    assign byte_sent    = byte_sent_q;
    assign busy_timeout = busy_timeout_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= F_IDLE;
            cnt_q          <= '0;
            tx_en_q        <= 1'b0;
            tx_data_q      <= '0;
            byte_sent_q    <= 1'b0;
            busy_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tx_en_q        <= tx_en_d;
            tx_data_q      <= tx_data_d;
            byte_sent_q    <= byte_sent_d;
            busy_timeout_q <= busy_timeout_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            F_IDLE:      state_d = launch ? F_WAIT_BUSY : F_IDLE;
            F_WAIT_BUSY: state_d = tx_busy ? F_WAIT_DONE : (timed_out ? F_IDLE : F_WAIT_BUSY);
            F_WAIT_DONE: state_d = tx_busy ? F_WAIT_DONE : F_IDLE;
            default:     state_d = F_IDLE;
        endcase
    end
    // A timed-out launch drops its byte; the error flag stays until reset.
    always_comb begin
        tx_en_d        = launch;
        tx_data_d      = launch ? head : tx_data_q;
        byte_sent_d    = state_q == F_WAIT_DONE && !tx_busy;
        busy_timeout_d = busy_timeout_q || timed_out;
        cnt_d          = (state_q == F_WAIT_BUSY && !tx_busy) ? cnt_q + CNT_W'(1) : '0;
    end
endmodule
